sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive m1 grants while m0 is pending (legal 1..15; fixed-priority build only).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports m0_addr  input  23 ([24:2]); m0_din  input  32; m0_lane  input  4; m0_wr  input  1; m0_valid  input  1. These form the instruction-fetch requester.
REQ-005 SHALL have ports m0_dout  output  32 and m0_ready  output  1, a one-cycle completion pulse.
REQ-006 SHALL have ports m1_addr, m1_din, m1_lane, m1_wr, m1_valid, m1_dout and m1_ready, with the same widths and meaning as m0. These form the data requester.
REQ-007 SHALL have ports mem_addr  output  23; mem_din  output  32; mem_lane  output  4; mem_wr  output  1; mem_valid  output  1. These drive the SDRAM controller CPU port.
REQ-008 SHALL have ports mem_dout  input  32 and mem_ready  input  1, a registered one-cycle completion pulse from the controller.

Function
REQ-009 SHALL implement a state machine with two states: S_IDLE and S_BUSY.
REQ-010 S_IDLE SHALL, when any mX_valid is high, register the winner in grant (1 bit) and move to S_BUSY; with no request it SHALL stay in S_IDLE.
REQ-011 S_BUSY SHALL stay until mem_ready is 1, then return to S_IDLE on the next edge.
REQ-012 mem_addr, mem_din, mem_lane and mem_wr SHALL be muxed from the master selected by the registered grant, so they stay stable for the whole access.
REQ-013 mem_valid SHALL equal (state == S_BUSY) AND NOT mem_ready, so the controller never sees valid in the cycle of ready and never starts a duplicate access.
REQ-014 mX_ready SHALL equal mem_ready AND (grant == X), combinationally; the other master's ready SHALL stay 0.
REQ-015 m0_dout and m1_dout SHALL both equal mem_dout combinationally; each is valid only with that master's ready.
REQ-016 The S_IDLE cycle after each completion SHALL serve as the mandatory one-cycle dead cycle for the controller; back-to-back accesses therefore start every (controller latency + 2) cycles.
REQ-017 The arbiter SHALL never return to S_IDLE without mem_ready; it has no timeout and no abort.
REQ-018 A master SHALL hold valid and its request fields until its ready; the arbiter SHALL sample mX_valid only in S_IDLE.
REQ-019 A master dropping valid while not granted SHALL be ignored without side effects.
REQ-020 Simultaneous m0_valid and m1_valid in S_IDLE SHALL be resolved per the Configuration section.
REQ-021 The 4-bit starve counter SHALL increment on each m1 grant made while m0_valid is high.
REQ-022 The starve counter SHALL clear on any m0 grant.
REQ-023 The starve counter SHALL saturate at STARVE_MAX.

Reset
REQ-024 On reset_n low, state SHALL be S_IDLE, grant SHALL be 0, the starve counter SHALL be 0, and the round-robin pointer SHALL be 0, asynchronously.
REQ-025 During and after reset, mem_valid, m0_ready and m1_ready SHALL be 0.
REQ-026 On reset asserted mid-access, the arbiter SHALL drop the access immediately; a mem_ready arriving after reset release while in S_IDLE SHALL be ignored and SHALL produce no mX_ready.

Configuration
REQ-027 With macro ARB_ROUND_ROBIN_EN defined, ties SHALL be resolved by a 1-bit pointer: the master not granted last wins.
REQ-028 With ARB_ROUND_ROBIN_EN defined, the pointer SHALL update on every grant, and STARVE_MAX and the starve counter SHALL be unused.
REQ-029 Without ARB_ROUND_ROBIN_EN, m1 SHALL have fixed priority, except that m0 SHALL win when the starve counter equals STARVE_MAX.

Verification
REQ-030 A single m0 read at 0x000100, with mem_ready 5 cycles after mem_valid rises, SHALL produce m0_ready for exactly 1 cycle, m0_dout == mem_dout, mem_valid low in the ready cycle, and m1_ready == 0.
REQ-031 m0_valid and m1_valid raised in the same cycle (fixed priority) SHALL grant m1 first and then m0, with exactly one S_IDLE cycle with mem_valid = 0 between the two accesses.
REQ-032 m1 requesting continuously with m0 pending (STARVE_MAX = 4, fixed priority) SHALL produce the grant sequence m1, m1, m1, m1, m0, m1.
REQ-033 With ARB_ROUND_ROBIN_EN defined and both masters requesting continuously, grants SHALL strictly alternate, starting with m0 after reset.
REQ-034 An m1 write (lane 4'b0011, din 0xDEADBEEF) SHALL hold mem_addr, mem_din, mem_lane and mem_wr stable from grant until mem_ready, even if m0_addr toggles every cycle.
REQ-035 reset_n pulsed low in S_BUSY, followed by a late mem_ready, SHALL give mem_valid = 0 immediately and no m0_ready or m1_ready pulse.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-master arbiter (m0 instruction fetch, m1 data) in front of
// the SDRAM controller CPU port. One access in flight; the S_IDLE cycle after
// each completion doubles as the controller's dead cycle.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking; the
// default build gives m1 fixed priority with a starvation guard for m0.
module sdram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  // instruction-fetch requester
  input  logic [22:0] m0_addr,
  input  logic [31:0] m0_din,
  input  logic [3:0]  m0_lane,
  input  logic        m0_wr,
  input  logic        m0_valid,
  output logic [31:0] m0_dout,
  output logic        m0_ready,
  // data requester
  input  logic [22:0] m1_addr,
  input  logic [31:0] m1_din,
  input  logic [3:0]  m1_lane,
  input  logic        m1_wr,
  input  logic        m1_valid,
  output logic [31:0] m1_dout,
  output logic        m1_ready,
  // SDRAM controller CPU port
  output logic [22:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_lane,
  output logic        mem_wr,
  output logic        mem_valid,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   grant;       // 0: m0 owns the port, 1: m1 owns the port
  logic   grant_nxt;
  logic   win;         // master that would be granted this cycle
  logic   grant_fire;  // a grant is made at the coming edge

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;        // master preferred on a tie (the one not granted last)
  logic rr_ptr_nxt;
`else
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
`endif

  // State, grant and tie-break bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr     <= 1'b0;
`else
      starve_cnt <= '0;
`endif
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr     <= rr_ptr_nxt;
`else
      starve_cnt <= starve_nxt;
`endif
    end
  end

  // Next state: pick a winner in S_IDLE, hold the access until mem_ready
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    win        = 1'b0;
    grant_fire = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_nxt = rr_ptr;
    if (m0_valid && m1_valid) win = rr_ptr;
    else                      win = m1_valid;
`else
    starve_nxt = starve_cnt;
    // m1 wins unless m0 has waited through STARVE_MAX m1 grants
    win = m1_valid && !(m0_valid && (starve_cnt == CNT_W'(STARVE_MAX)));
`endif

    case (state)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt  = S_BUSY;
          grant_nxt  = win;
          grant_fire = 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_ready) state_nxt = S_IDLE;
      end
    endcase

`ifdef ARB_ROUND_ROBIN_EN
    if (grant_fire) rr_ptr_nxt = ~win;
`else
    if (grant_fire) begin
      if (!win) begin
        starve_nxt = '0;
      end else if (m0_valid && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_nxt = starve_cnt + CNT_W'(1);
      end
    end
`endif
  end

  // Outputs: request mux from the registered grant, ready steered to the owner
  always_comb begin
    mem_addr  = m0_addr;
    mem_din   = m0_din;
    mem_lane  = m0_lane;
    mem_wr    = m0_wr;
    mem_valid = 1'b0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_dout   = mem_dout;
    m1_dout   = mem_dout;
    if (grant) begin
      mem_addr = m1_addr;
      mem_din  = m1_din;
      mem_lane = m1_lane;
      mem_wr   = m1_wr;
    end
    // ready only counts while an access is outstanding; a stray one after reset is dropped
    if (state == S_BUSY) begin
      mem_valid = !mem_ready;
      m0_ready  = mem_ready && !grant;
      m1_ready  = mem_ready && grant;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int unsigned STARVE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [22:0] a_addr [2];
  logic [31:0] a_din  [2];
  logic [3:0]  a_lane [2];
  logic        a_wr   [2];
  logic        a_val  [2];
  logic [31:0] m0_dout, m1_dout;
  logic        m0_ready, m1_ready;
  logic [22:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_lane;
  logic        mem_wr, mem_valid;
  logic [31:0] mem_dout;
  logic        mem_ready;

  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  sdram_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(a_addr[0]), .m0_din(a_din[0]), .m0_lane(a_lane[0]), .m0_wr(a_wr[0]),
    .m0_valid(a_val[0]), .m0_dout(m0_dout), .m0_ready(m0_ready),
    .m1_addr(a_addr[1]), .m1_din(a_din[1]), .m1_lane(a_lane[1]), .m1_wr(a_wr[1]),
    .m1_valid(a_val[1]), .m1_dout(m1_dout), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_lane(mem_lane), .mem_wr(mem_wr),
    .mem_valid(mem_valid), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      a_val[m]  = 1'b0;
      a_addr[m] = '0;
      a_din[m]  = '0;
      a_lane[m] = '0;
      a_wr[m]   = 1'b0;
    end
    mem_ready = 1'b0;
    mem_dout  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    a_val[0]  = 1'b1;
    a_val[1]  = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if ({mem_valid, m0_ready, m1_ready} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got valid/r0/r1=%b%b%b exp=000", i, mem_valid, m0_ready, m1_ready);
      end
      @(negedge clk);
    end
    idle_inputs();
    reset_n = 1'b1;
    #1;
    n_vec++;
    if ({mem_valid, m0_ready, m1_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release got valid/r0/r1=%b%b%b exp=000", mem_valid, m0_ready, m1_ready);
    end
  endtask

  task automatic test_single_read();
    logic [31:0] d;
    do_reset();
    @(negedge clk);
    a_val[0]  = 1'b1;
    a_addr[0] = 23'h000040;
    a_wr[0]   = 1'b0;
    a_lane[0] = 4'hF;
    a_din[0]  = $urandom;
    #1;
    n_vec++;
    if (mem_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_idle got mem_valid=%b exp=0", mem_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if ({mem_valid, mem_addr, mem_wr, m0_ready} !== {1'b1, 23'h000040, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL read_busy cyc=%0d got valid=%b addr=%h wr=%b r0=%b exp 1/000040/0/0",
                 i, mem_valid, mem_addr, mem_wr, m0_ready);
      end
    end
    @(negedge clk);
    d = $urandom;
    mem_ready = 1'b1;
    mem_dout  = d;
    #1;
    n_vec++;
    if ({m0_ready, m1_ready, mem_valid, m0_dout} !== {1'b1, 1'b0, 1'b0, d}) begin
      n_err++;
      $display("FAIL read_done got r0=%b r1=%b valid=%b dout=%h exp 1/0/0/%h",
               m0_ready, m1_ready, mem_valid, m0_dout, d);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    a_val[0]  = 1'b0;
    #1;
    n_vec++;
    if ({m0_ready, mem_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL read_after got r0=%b valid=%b exp 0/0", m0_ready, mem_valid);
    end
  endtask

  task automatic test_tie();
    int first;
    int second;
`ifdef ARB_ROUND_ROBIN_EN
    first = 0;
`else
    first = 1;
`endif
    second = 1 - first;
    do_reset();
    @(negedge clk);
    a_val[0] = 1'b1;  a_addr[0] = 23'h011111;
    a_val[1] = 1'b1;  a_addr[1] = 23'h022222;
    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? first : second;
      @(negedge clk);
      #1;
      n_vec++;
      if ({mem_valid, mem_addr} !== {1'b1, a_addr[w]}) begin
        n_err++;
        $display("FAIL tie_grant%0d got valid=%b addr=%h exp 1/%h", k, mem_valid, mem_addr, a_addr[w]);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n_vec++;
      if ({m1_ready, m0_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL tie_ready%0d got r1r0=%b%b exp owner m%0d", k, m1_ready, m0_ready, w);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      a_val[w]  = 1'b0;
      #1;
      n_vec++;
      if ({mem_valid, m0_ready, m1_ready} !== 3'b000) begin
        n_err++;
        $display("FAIL tie_dead%0d got valid/r0/r1=%b%b%b exp=000", k, mem_valid, m0_ready, m1_ready);
      end
    end
  endtask

  task automatic test_starve();
    int   seq[$];
    int   exp[6];
    logic nr;
`ifdef ARB_ROUND_ROBIN_EN
    exp = '{0, 1, 0, 1, 0, 1};
`else
    exp = '{1, 1, 1, 1, 0, 1};
`endif
    nr = 1'b0;
    do_reset();
    @(negedge clk);
    a_val[0] = 1'b1;
    a_val[1] = 1'b1;
    for (int cyc = 0; cyc < 200 && seq.size() < 6; cyc++) begin
      @(negedge clk);
      mem_ready = nr;
      mem_dout  = $urandom;
      #1;
      if (m0_ready) seq.push_back(0);
      if (m1_ready) seq.push_back(1);
      nr = mem_valid;
    end
    @(negedge clk);
    idle_inputs();
    n_vec++;
    if (seq.size() != 6) begin
      n_err++;
      $display("FAIL starve_count got %0d grants exp 6", seq.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= seq.size()) begin
        n_err++;
        $display("FAIL starve_seq[%0d] got none exp m%0d", i, exp[i]);
      end else if (seq[i] != exp[i]) begin
        n_err++;
        $display("FAIL starve_seq[%0d] got m%0d exp m%0d", i, seq[i], exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [59:0] exp;
    logic [31:0] d;
    do_reset();
    @(negedge clk);
    a_val[1]  = 1'b1;
    a_wr[1]   = 1'b1;
    a_lane[1] = 4'b0011;
    a_din[1]  = 32'hDEADBEEF;
    a_addr[1] = 23'($urandom);
    exp = {a_addr[1], 32'hDEADBEEF, 4'b0011, 1'b1};
    d = $urandom;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_addr[0] = 23'($urandom);
      a_din[0]  = $urandom;
      a_lane[0] = 4'($urandom);
      a_wr[0]   = 1'($urandom);
      mem_ready = (i == 5);
      mem_dout  = d;
      #1;
      n_vec++;
      if ({mem_valid, mem_addr, mem_din, mem_lane, mem_wr} !== {(i != 5), exp}) begin
        n_err++;
        $display("FAIL hold_fields cyc=%0d got %b_%h_%h_%b_%b exp %b_%h", i,
                 mem_valid, mem_addr, mem_din, mem_lane, mem_wr, (i != 5), exp);
      end
    end
    n_vec++;
    if ({m1_ready, m0_ready, m1_dout} !== {1'b1, 1'b0, d}) begin
      n_err++;
      $display("FAIL hold_done got r1=%b r0=%b dout=%h exp 1/0/%h", m1_ready, m0_ready, m1_dout, d);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    a_val[1]  = 1'b1;
    a_addr[1] = 23'($urandom);
    @(negedge clk);
    #1;
    n_vec++;
    if (mem_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy got mem_valid=%b exp=1", mem_valid);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_valid, m0_ready, m1_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_drop got valid/r0/r1=%b%b%b exp=000", mem_valid, m0_ready, m1_ready);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    a_val[1] = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_dout  = $urandom;
    #1;
    n_vec++;
    if ({mem_valid, m0_ready, m1_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_late got valid/r0/r1=%b%b%b exp=000", mem_valid, m0_ready, m1_ready);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_vec++;
    if ({mem_valid, m0_ready, m1_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_after got valid/r0/r1=%b%b%b exp=000", mem_valid, m0_ready, m1_ready);
    end
  endtask

  task automatic test_random();
    bit          busy;
    int          owner;
    int          lat;
    int unsigned cnt;
    int          ptr;
    int          rel;
    int          w;
    logic [59:0] snap;
    logic [31:0] d;
    busy = 1'b0; owner = 0; lat = 0; cnt = 0; ptr = 0; rel = -1; w = 0; snap = '0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (rel >= 0) begin
        a_val[rel] = 1'b0;
        rel = -1;
      end
      for (int m = 0; m < 2; m++) begin
        if (!a_val[m]) begin
          a_addr[m] = 23'($urandom);
          a_din[m]  = $urandom;
          a_lane[m] = 4'($urandom);
          a_wr[m]   = 1'($urandom);
          a_val[m]  = ($urandom_range(0, 2) == 0);
        end else if (!(busy && owner == m) && $urandom_range(0, 19) == 0) begin
          a_val[m] = 1'b0;
        end
      end
      mem_ready = busy && (lat == 0);
      d = $urandom;
      mem_dout = d;
      #1;
      n_vec++;
      if (mem_valid !== (busy && !mem_ready)) begin
        n_err++;
        $display("FAIL rand_valid cyc=%0d got %b exp %b", cyc, mem_valid, busy && !mem_ready);
      end
      n_vec++;
      if ({m0_ready, m1_ready} !== {busy && mem_ready && owner == 0, busy && mem_ready && owner == 1}) begin
        n_err++;
        $display("FAIL rand_ready cyc=%0d got r0r1=%b%b owner=m%0d busy=%0d", cyc, m0_ready, m1_ready, owner, busy);
      end
      if (busy) begin
        n_vec++;
        if ({mem_addr, mem_din, mem_lane, mem_wr} !== snap) begin
          n_err++;
          $display("FAIL rand_fields cyc=%0d got %h_%h_%h_%b exp %h", cyc, mem_addr, mem_din, mem_lane, mem_wr, snap);
        end
      end
      if (mem_ready) begin
        n_vec++;
        if ({m0_dout, m1_dout} !== {d, d}) begin
          n_err++;
          $display("FAIL rand_dout cyc=%0d got %h/%h exp %h", cyc, m0_dout, m1_dout, d);
        end
      end
      // model the coming clock edge
      if (busy) begin
        if (mem_ready) begin
          busy = 1'b0;
          rel  = owner;
        end else begin
          lat--;
        end
      end else if (a_val[0] || a_val[1]) begin
        if (a_val[0] && a_val[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
          w = ptr;
`else
          w = (cnt == STARVE) ? 0 : 1;
`endif
        end else begin
          w = a_val[1] ? 1 : 0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        ptr = 1 - w;
`else
        if (w == 0) cnt = 0;
        else if (a_val[0]) cnt = (cnt + 1 > STARVE) ? STARVE : cnt + 1;
`endif
        busy  = 1'b1;
        owner = w;
        lat   = $urandom_range(1, 5);
        snap  = {a_addr[w], a_din[w], a_lane[w], a_wr[w]};
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_starve();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
